// File: rtl/polygon_issue_unit.sv
// Polygon issue unit: for each accepted pixel request, scans every polygon slot from a
// synchronous memory and issues one (pixel, polygon) pair per cycle with a slot tag.
module polygon_issue_unit #(
  parameter int unsigned NUM_SLOTS = 16,
  parameter int unsigned ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_valid,
  input  logic [9:0]        pixel_x_in,
  input  logic [9:0]        pixel_y_in,
  output logic              ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  output logic [9:0]        pixel_x,
  output logic [9:0]        pixel_y,
  output logic [8:0]        ref_point_x,
  output logic [8:0]        ref_point_y,
  output logic [8:0]        in_color,
  output logic [3:0]        mult,
  output logic              form,
  output logic              in_bubble,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_slot,
  output logic              out_first,
  output logic              out_last
);

  localparam logic [ADDR_W-1:0] LastSlot = ADDR_W'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StIssue} state_e;

  state_e            state_q, state_d;
  logic [9:0]        req_x_q, req_x_d;
  logic [9:0]        req_y_q, req_y_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;

  logic [9:0]        pix_x_q, pix_x_d;
  logic [9:0]        pix_y_q, pix_y_d;
  logic [8:0]        ref_x_q, ref_x_d;
  logic [8:0]        ref_y_q, ref_y_d;
  logic [8:0]        color_q, color_d;
  logic [3:0]        mult_q, mult_d;
  logic              form_q, form_d;
  logic              bubble_q, bubble_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] slot_q, slot_d;
  logic              first_q, first_d;
  logic              last_q, last_d;

  // Memory entry fields
  logic       ent_form;
  logic [3:0] ent_mult;
  logic [8:0] ent_color;
  logic [8:0] ent_ref_y;
  logic [8:0] ent_ref_x;

  assign ent_form  = mem_rdata[31];
  assign ent_mult  = mem_rdata[30:27];
  assign ent_color = mem_rdata[26:18];
  assign ent_ref_y = mem_rdata[17:9];
  assign ent_ref_x = mem_rdata[8:0];

  always_comb begin
    state_d  = state_q;
    req_x_d  = req_x_q;
    req_y_d  = req_y_q;
    rd_idx_d = rd_idx_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    pix_x_d  = pix_x_q;
    pix_y_d  = pix_y_q;
    ref_x_d  = ref_x_q;
    ref_y_d  = ref_y_q;
    color_d  = color_q;
    mult_d   = mult_q;
    form_d   = form_q;
    slot_d   = slot_q;
    // Idle-cycle flag values; data fields hold their last issued value
    bubble_d = 1'b1;
    valid_d  = 1'b0;
    first_d  = 1'b0;
    last_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pixel_valid) begin
          req_x_d = pixel_x_in;
          req_y_d = pixel_y_in;
          addr_d  = '0;
          rd_d    = 1'b1;
          state_d = StFetch;
        end
      end
      StFetch: begin
        addr_d   = ADDR_W'(1);
        rd_idx_d = '0;
        state_d  = StIssue;
      end
      StIssue: begin
        pix_x_d  = req_x_q;
        pix_y_d  = req_y_q;
        ref_x_d  = ent_ref_x;
        ref_y_d  = ent_ref_y;
        color_d  = ent_color;
        mult_d   = ent_mult;
        form_d   = ent_form;
        bubble_d = (ent_mult == 4'd0);
        valid_d  = 1'b1;
        slot_d   = rd_idx_q;
        first_d  = (rd_idx_q == '0);
        last_d   = (rd_idx_q == LastSlot);
        // Address saturates at the last slot; the read strobe ends once it was presented
        if (addr_q == LastSlot) begin
          rd_d = 1'b0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
        if (rd_idx_q == LastSlot) begin
          state_d = StIdle;
        end else begin
          rd_idx_d = rd_idx_q + ADDR_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      req_x_q  <= '0;
      req_y_q  <= '0;
      rd_idx_q <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      pix_x_q  <= '0;
      pix_y_q  <= '0;
      ref_x_q  <= '0;
      ref_y_q  <= '0;
      color_q  <= '0;
      mult_q   <= '0;
      form_q   <= 1'b0;
      bubble_q <= 1'b1;
      valid_q  <= 1'b0;
      slot_q   <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_x_q  <= req_x_d;
      req_y_q  <= req_y_d;
      rd_idx_q <= rd_idx_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      pix_x_q  <= pix_x_d;
      pix_y_q  <= pix_y_d;
      ref_x_q  <= ref_x_d;
      ref_y_q  <= ref_y_d;
      color_q  <= color_d;
      mult_q   <= mult_d;
      form_q   <= form_d;
      bubble_q <= bubble_d;
      valid_q  <= valid_d;
      slot_q   <= slot_d;
      first_q  <= first_d;
      last_q   <= last_d;
    end
  end

  assign ready       = (state_q == StIdle);
  assign mem_addr    = addr_q;
  assign mem_rd      = rd_q;
  assign pixel_x     = pix_x_q;
  assign pixel_y     = pix_y_q;
  assign ref_point_x = ref_x_q;
  assign ref_point_y = ref_y_q;
  assign in_color    = color_q;
  assign mult        = mult_q;
  assign form        = form_q;
  assign in_bubble   = bubble_q;
  assign out_valid   = valid_q;
  assign out_slot    = slot_q;
  assign out_first   = first_q;
  assign out_last    = last_q;

endmodule
